// File: rtl/sigmeas_pkg.sv
// rtl/sigmeas_pkg.sv - shared types and constants for the signal measurement blocks
package sigmeas_pkg;

    typedef enum logic {
        ST_UNARMED = 1'b0,
        ST_MEASURE = 1'b1
    } meas_state_t;

    localparam int          PHASE_W  = 32;
    localparam int          DIV_ITER = 33;
    localparam logic [32:0] DIVIDEND = 33'h1_0000_0000;

endpackage

// File: rtl/recip_div.sv
// rtl/recip_div.sv - sequential restoring divider computing floor(2^32 / divisor)
module recip_div
    import sigmeas_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PHASE_W-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [PHASE_W-1:0] quotient
);

    logic               busy_q, busy_d;
    logic [5:0]         iter_q, iter_d;
    logic [32:0]        dvd_q, dvd_d;
    logic [32:0]        rem_q, rem_d;
    logic [PHASE_W-1:0] quo_q, quo_d;
    logic [PHASE_W-1:0] dvs_q, dvs_d;

    logic [32:0] trial;
    logic [32:0] diff;
    logic        ge;

    always_comb begin
        trial  = {rem_q[31:0], dvd_q[32]};
        diff   = trial - {1'b0, dvs_q};
        ge     = (trial >= {1'b0, dvs_q});
        busy_d = busy_q;
        iter_d = iter_q;
        dvd_d  = dvd_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        if (start && !busy_q) begin
            busy_d = 1'b1;
            iter_d = '0;
            dvd_d  = DIVIDEND;
            rem_d  = '0;
            quo_d  = '0;
            dvs_d  = divisor;
        end else if (busy_q) begin
            if (iter_q == 6'(DIV_ITER)) begin
                busy_d = 1'b0;
            end else begin
                // Quotient bit 32 is shifted out of the 32-bit register; it is always 0.
                rem_d  = ge ? diff : trial;
                dvd_d  = {dvd_q[31:0], 1'b0};
                quo_d  = {quo_q[PHASE_W-2:0], ge};
                iter_d = iter_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            iter_q <= '0;
            dvd_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            iter_q <= iter_d;
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (iter_q == 6'(DIV_ITER));
    assign quotient = quo_q;

endmodule

// File: rtl/square_freq_meter.sv
// rtl/square_freq_meter.sv - square wave period meter with reciprocal phase-step estimate
module square_freq_meter
    import sigmeas_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               square_in,
    output logic [PHASE_W-1:0] period_out,
    output logic [PHASE_W-1:0] phase_step_out,
    output logic               valid,
    output logic               no_signal,
    output logic               overrun
);

    logic sync1_q, sync2_q, prev_q, edge_q;

    meas_state_t        state_q, state_d;
    logic [PHASE_W-1:0] count_q, count_d;
    logic [PHASE_W-1:0] pend_q, pend_d;
    logic [PHASE_W-1:0] period_q, period_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               valid_q, valid_d;
    logic               no_signal_q, no_signal_d;
    logic               overrun_q, overrun_d;

    logic               div_start, div_busy, div_done;
    logic [PHASE_W-1:0] div_quotient;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= square_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pend_d      = pend_q;
        period_d    = period_q;
        phase_d     = phase_q;
        valid_d     = 1'b0;
        no_signal_d = no_signal_q;
        overrun_d   = overrun_q;
        div_start   = 1'b0;
        case (state_q)
            ST_UNARMED: begin
                count_d = '0;
                if (edge_q) begin
                    state_d     = ST_MEASURE;
                    count_d     = 32'd1;
                    no_signal_d = 1'b0;
                end
            end
            ST_MEASURE: begin
                count_d = count_q + 32'd1;
                if (edge_q) begin
                    count_d = 32'd1;
                    if (div_busy) begin
                        overrun_d = 1'b1;
                    end else begin
                        div_start = 1'b1;
                        pend_d    = count_q;
                    end
                end else if (count_q == TIMEOUT_CYCLES) begin
                    state_d     = ST_UNARMED;
                    count_d     = '0;
                    no_signal_d = 1'b1;
                    period_d    = '0;
                    phase_d     = '0;
                end
            end
            default: state_d = ST_UNARMED;
        endcase
        // A divide started before a timeout still publishes its result.
        if (div_done) begin
            period_d = pend_q;
            phase_d  = div_quotient;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNARMED;
            count_q     <= '0;
            pend_q      <= '0;
            period_q    <= '0;
            phase_q     <= '0;
            valid_q     <= 1'b0;
            no_signal_q <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            period_q    <= period_d;
            phase_q     <= phase_d;
            valid_q     <= valid_d;
            no_signal_q <= no_signal_d;
            overrun_q   <= overrun_d;
        end
    end

    recip_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .divisor  (count_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    assign period_out     = period_q;
    assign phase_step_out = phase_q;
    assign valid          = valid_q;
    assign no_signal      = no_signal_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_square_freq_meter.sv
// tb/tb_square_freq_meter.sv - scoreboard bench for square_freq_meter
module tb_square_freq_meter;

    localparam int unsigned T = 1100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        square_in = 1'b0;
    logic [31:0] period_out;
    logic [31:0] phase_step_out;
    logic        valid;
    logic        no_signal;
    logic        overrun;

    typedef struct {
        logic [31:0] per;
        logic [31:0] ph;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   armed = 1'b0;
    bit   acc_seen = 1'b0;
    int   t_prev = 0;
    int   t_acc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    square_freq_meter #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .square_in      (square_in),
        .period_out     (period_out),
        .phase_step_out (phase_step_out),
        .valid          (valid),
        .no_signal      (no_signal),
        .overrun        (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got period %0d, nothing expected", period_out);
            end else begin
                e = q.pop_front();
                check("period", period_out, e.per);
                check("phase_step", phase_step_out, e.ph);
            end
        end
    end

    // Rising pin edge; the first edge after arming produces no result, and a
    // result is only expected when 35+ cycles have passed since the last accepted edge.
    task automatic rise(input logic [31:0] per, input logic [31:0] ph);
        square_in = 1'b1;
        if (!armed) begin
            armed    = 1'b1;
            acc_seen = 1'b0;
        end else if (!acc_seen || (cyc - t_acc) >= 35) begin
            q.push_back('{per, ph});
            t_acc    = cyc;
            acc_seen = 1'b1;
        end
        t_prev = cyc;
    endtask

    task automatic gen(input int hi, input int lo, input int n,
                       input logic [31:0] per, input logic [31:0] ph);
        repeat (n) begin
            rise(per, ph);
            repeat (hi) @(negedge clk);
            square_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        check("pending_results", q.size(), 0);
        q.delete();
        @(negedge clk);
        rst_n     = 1'b0;
        square_in = 1'b0;
        armed     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        int tl;
        repeat (3) @(negedge clk);
        check("rst_no_signal", no_signal, 1);
        check("rst_period", period_out, 0);
        check("rst_phase", phase_step_out, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 100-cycle period: five results, no overrun
        gen(50, 50, 6, 32'd100, 32'd42949672);
        check("p100_overrun", overrun, 0);
        check("p100_no_signal", no_signal, 0);
        check("p100_hold_period", period_out, 100);

        // reset while a divide is in flight
        square_in = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        armed = 1'b0;
        @(negedge clk);
        check("mid_rst_no_signal", no_signal, 1);
        check("mid_rst_period", period_out, 0);
        check("mid_rst_phase", phase_step_out, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_overrun", overrun, 0);
        square_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rise(32'd0, 32'd0);
        repeat (60) @(negedge clk);
        square_in = 1'b0;
        repeat (5) @(negedge clk);
        check("one_edge_no_signal", no_signal, 0);
        check("one_edge_period", period_out, 0);

        // loopback of a generator at phase_step 0x0040_0000
        do_reset();
        gen(512, 512, 3, 32'd1024, 32'h0040_0000);
        check("p1024_overrun", overrun, 0);

        // minimum period: later edges collide with the busy divider
        do_reset();
        gen(1, 1, 40, 32'd2, 32'h8000_0000);
        repeat (40) @(negedge clk);
        check("p2_overrun", overrun, 1);
        repeat (100) @(negedge clk);
        check("p2_overrun_sticky", overrun, 1);

        // timeout after the signal stops, then re-arm
        do_reset();
        gen(50, 50, 3, 32'd100, 32'd42949672);
        tl = t_prev;
        n = 0;
        while (!no_signal && n < 1300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_seen", no_signal, 1);
        check("timeout_latency", cyc - tl, T + 4);
        check("timeout_period", period_out, 0);
        check("timeout_phase", phase_step_out, 0);
        armed = 1'b0;
        gen(50, 50, 2, 32'd100, 32'd42949672);
        check("rearm_period", period_out, 100);
        check("rearm_no_signal", no_signal, 0);

        // edge in the same cycle the count reaches the timeout
        do_reset();
        gen(550, 550, 2, 32'd1100, 32'd3904515);
        check("boundary_no_signal", no_signal, 0);
        check("boundary_period", period_out, 1100);

        repeat (50) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/square_freq_meter.md
# square_freq_meter

Measures the frequency of an incoming square wave and recovers the 32-bit phase increment that would reproduce it on the team's phase-accumulator generators. Sits on the analysis/test side of the signal-generator path: a generator's square output loops into this block, and the block reports the period in clock cycles plus `floor(2^32 / period)` as a phase-step estimate. The input is asynchronous. Measurement is rising-edge to rising-edge, with timeout detection for a missing or stalled signal.

## Interface
- `TIMEOUT_CYCLES`, default 16777216: number of cycles without a rising edge before the signal is declared lost. Legal range 4..2^32-1.
- `clk`  input  1: system clock.
- `rst_n`  input  1: asynchronous, active-low reset.
- `square_in`  input  1: square wave under test, asynchronous to `clk`.
- `period_out`  output  32: last measured period, in clock cycles.
- `phase_step_out`  output  32: `floor(2^32 / period_out)`.
- `valid`  output  1: one-cycle pulse when `period_out` and `phase_step_out` update together.
- `no_signal`  output  1: level. High while unarmed after reset or after a timeout.
- `overrun`  output  1: sticky. Set when a measurement is dropped because the divider is busy. Cleared only by reset.

## Operation
- **Input conditioning.**
  - Two-flop synchronizer on `square_in`, then a registered rising-edge detect producing `edge_p`.
  - Pin-to-`edge_p` latency is 3 cycles.
  - Consecutive `edge_p` pulses are therefore at least 2 cycles apart.
- **FSM states:** UNARMED and MEASURE.
  - **UNARMED (reset state).** `no_signal`=1, cycle counter held at 0. On `edge_p`: go to MEASURE, set count to 1, drop `no_signal` to 0. No measurement is produced for this first edge.
  - **MEASURE.** Counter increments every cycle.
  - **MEASURE, `edge_p` with divider idle.** Latch `count` as the period, start the divider, restart count at 1.
  - **MEASURE, `edge_p` with divider busy.** Discard the measurement, set `overrun`, restart count at 1.
  - **MEASURE, timeout.** If `count` reaches `TIMEOUT_CYCLES` with no `edge_p` in that cycle: go to UNARMED, set `no_signal`=1, and clear `period_out` and `phase_step_out` to 0 with no `valid` pulse.
  - **Simultaneous `edge_p` and timeout.** The edge wins and a normal measurement is taken.
- **Divider.**
  - Restoring, radix-2, unsigned. Dividend is 2^32 (33 bits), divisor is the latched period (≥2).
  - One quotient bit per cycle, 33 iterations. The quotient fits in 32 bits because period ≥ 2.
  - Quotient bit 32 is always 0 and is discarded.
  - A timeout while the divider is busy does not abort it. The result is still published with `valid`, but `no_signal` stays 1.
- **Counter arithmetic.** 32 bits wide. It cannot wrap because timeout occurs before 2^32.

## Timing
- **Reset values.** All outputs are 0 except `no_signal`=1. FSM is in UNARMED and the divider is idle.
- **Measurement latency.** Let the clock edge that samples `edge_p`=1 be edge E.
  - The divider loads at E and iterates during cycles E+1..E+33.
  - `period_out`, `phase_step_out` and `valid` are registered at E+34.
  - `valid` is high for exactly one cycle.
- **Throughput.** The divider is busy from E through E+34.
  - A following edge within 34 cycles of E is an overrun.
  - Periods ≥ 35 cycles never overrun.
- **Outputs hold** their values between `valid` pulses. The only other change is the clear on timeout.
- **Reset asserted mid-divide** aborts immediately. No `valid` is produced and all state returns to reset values.

## Structure
- **Shared package `sigmeas_pkg`:**
  - FSM state enum `meas_state_t`.
  - `PHASE_W` = 32.
  - `DIV_ITER` = 33.
  - `DIVIDEND` = 33'h1_0000_0000.
- **Sub-module `recip_div`:**
  - Ports: `clk`, `rst_n`, `start`, 32-bit `divisor`, `busy`, `done`, 32-bit `quotient`.
  - Fixed dividend of 2^32, sequential, one bit per cycle.
  - The top level owns the synchronizer, edge detect, counter, FSM and output registers.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-stream → `no_signal`=1, `period_out`=0, `phase_step_out`=0, `valid`=0, `overrun`=0. After release and one edge, no `valid` pulse occurs.
- **Period 100.** Drive `square_in` with a 100-cycle period → after the second edge `valid` pulses, `period_out`=100, `phase_step_out`=42949672. This repeats every 100 cycles with no `overrun`.
- **Loopback with the square generator.** Generator at `phase_step`=32'h0040_0000 (1024-cycle period) → `period_out`=1024, `phase_step_out`=32'h0040_0000 exactly.
- **Minimum period.** `square_in` toggling every cycle (2-cycle period) → first result `period_out`=2, `phase_step_out`=32'h8000_0000. Later edges arrive while the divider is busy, so `overrun`=1 and stays set.
- **Timeout.** With `TIMEOUT_CYCLES`=1000, stop `square_in` after valid measurements → 1000 cycles after the last `edge_p`, `no_signal`=1 and both outputs are 0. On restart, the first edge gives no `valid` and the second edge gives a correct result.
- **Boundary.** An `edge_p` landing in the same cycle `count` reaches `TIMEOUT_CYCLES` → a measurement is taken with `period_out`=`TIMEOUT_CYCLES` and `no_signal` stays 0.
